// File: rtl/regfile_mmio.sv
// regfile_mmio: register file with r0 hardwired to zero, synchronised input-pin
// registers carrying a sticky change flag, and output registers driving pins.
module regfile_mmio #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int IN_BASE    = 26,
   parameter int NUM_IN     = 3,
   parameter int IN_WIDTH   = 8,
   parameter int OUT_BASE   = 25,
   parameter int NUM_OUT    = 1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                          clock,
   input  logic                          ctrl_reset,
   input  logic                          ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]         data_writeReg,
   input  logic [ADDR_WIDTH-1:0]         ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0]         ctrl_readRegB,
   output logic [DATA_WIDTH-1:0]         data_readRegA,
   output logic [DATA_WIDTH-1:0]         data_readRegB,
   input  logic [NUM_IN*IN_WIDTH-1:0]    io_in,
   output logic [NUM_OUT*DATA_WIDTH-1:0] io_out,
   output logic [NUM_IN-1:0]             io_changed
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   if (IN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < IN_BASE + NUM_IN) begin : g_err_overlap
      $error("input and output windows overlap");
   end
   if (IN_BASE == 0 || OUT_BASE == 0) begin : g_err_zero
      $error("I/O window includes r0");
   end
   if (IN_BASE + NUM_IN > NUM_REGS || OUT_BASE + NUM_OUT > NUM_REGS) begin : g_err_range
      $error("I/O window exceeds register file");
   end
   if (IN_WIDTH > DATA_WIDTH - 1) begin : g_err_width
      $error("IN_WIDTH leaves no room for the change flag");
   end

   logic [DATA_WIDTH-1:0]      regs_d [NUM_REGS];
   logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
   logic [NUM_IN*IN_WIDTH-1:0] s1_d, s1_q, s2_d, s2_q;

   function automatic logic is_in(input logic [ADDR_WIDTH-1:0] a);
      return int'(a) >= IN_BASE && int'(a) < IN_BASE + NUM_IN;
   endfunction

   function automatic logic fwd(input logic [ADDR_WIDTH-1:0] a);
      return BYPASS && ctrl_writeEnable && a == ctrl_writeReg && a != '0 && !is_in(a);
   endfunction

   always_comb begin
      s1_d = io_in;
      s2_d = s1_q;
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
         assign regs_d[i] = '0;
      end else if (i >= IN_BASE && i < IN_BASE + NUM_IN) begin : g_in
         localparam int K = i - IN_BASE;
         logic [IN_WIDTH-1:0] pin;
         logic                clr;
         assign pin = s2_q[K*IN_WIDTH +: IN_WIDTH];
         assign clr = ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i);
         // a fresh change sets the flag even when a CPU write clears it on the same edge
         assign regs_d[i] = DATA_WIDTH'({(pin != regs_q[i][IN_WIDTH-1:0]) | (regs_q[i][IN_WIDTH] & ~clr), pin});
         assign io_changed[K] = regs_q[i][IN_WIDTH];
      end else begin : g_gen
         assign regs_d[i] = (ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i)) ? data_writeReg : regs_q[i];
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
      assign io_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[OUT_BASE+k];
   end

   always_comb begin
      data_readRegA = (ctrl_readRegA == '0) ? '0 : fwd(ctrl_readRegA) ? data_writeReg : regs_q[ctrl_readRegA];
      data_readRegB = (ctrl_readRegB == '0) ? '0 : fwd(ctrl_readRegB) ? data_writeReg : regs_q[ctrl_readRegB];
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         regs_q <= '{default: '0};
         s1_q   <= '0;
         s2_q   <= '0;
      end else begin
         regs_q <= regs_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
      end
   end
endmodule

// File: tb/tb_regfile_mmio.sv
// tb_regfile_mmio: scoreboard bench for regfile_mmio with default parameters.
module tb_regfile_mmio;
   logic        clock = 1'b0;
   logic        ctrl_reset = 1'b1;
   logic        ctrl_writeEnable = 1'b0;
   logic [4:0]  ctrl_writeReg = '0;
   logic [31:0] data_writeReg = '0;
   logic [4:0]  ctrl_readRegA = '0;
   logic [4:0]  ctrl_readRegB = '0;
   logic [31:0] data_readRegA, data_readRegB;
   logic [23:0] io_in = 24'hFF00A5;
   logic [31:0] io_out;
   logic [2:0]  io_changed;

   int checks = 0;
   int errors = 0;
   string       tag_q [$];
   int          sel_q [$];
   logic [31:0] exp_q [$];

   regfile_mmio dut (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
      .io_in(io_in), .io_out(io_out), .io_changed(io_changed)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // sel: 0 read A, 1 read B, 2 io_out, 3 io_changed
   task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(v);
   endtask

   task automatic drain();
      logic [31:0] got;
      int          sel;
      #1;
      while (exp_q.size() > 0) begin
         sel = sel_q.pop_front();
         got = sel == 0 ? data_readRegA : sel == 1 ? data_readRegB : sel == 2 ? io_out : {29'b0, io_changed};
         check(tag_q.pop_front(), got, exp_q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = a;
      data_writeReg    = d;
   endtask

   initial begin
      ctrl_readRegA = 5'd26;
      ctrl_readRegB = 5'd28;
      tick();
      tick();
      expect_val("rst_a", 0, 32'h0);
      expect_val("rst_b", 1, 32'h0);
      expect_val("rst_out", 2, 32'h0);
      expect_val("rst_chg", 3, 32'h0);
      drain();
      ctrl_reset = 1'b0;
      tick();
      tick();
      expect_val("sync_e2", 0, 32'h0);
      drain();
      tick();
      expect_val("r26_e3", 0, 32'h1A5);
      expect_val("r28_e3", 1, 32'h1FF);
      expect_val("chg_e3", 3, 32'h5);
      drain();
      ctrl_readRegA = 5'd27;
      expect_val("r27_e3", 0, 32'h0);
      drain();

      wr(5'd5, 32'hDEADBEEF);
      ctrl_readRegA = 5'd5;
      expect_val("byp_r5", 0, 32'hDEADBEEF);
      drain();
      tick();
      ctrl_writeEnable = 1'b0;
      expect_val("r5_held", 0, 32'hDEADBEEF);
      drain();

      wr(5'd7, 32'h000055AA);
      ctrl_readRegA = 5'd7;
      ctrl_readRegB = 5'd7;
      expect_val("byp_r7_a", 0, 32'h55AA);
      expect_val("byp_r7_b", 1, 32'h55AA);
      drain();
      tick();

      wr(5'd0, 32'h1234);
      ctrl_readRegA = 5'd0;
      ctrl_readRegB = 5'd0;
      expect_val("r0_same_a", 0, 32'h0);
      expect_val("r0_same_b", 1, 32'h0);
      drain();
      tick();
      ctrl_writeEnable = 1'b0;
      expect_val("r0_next_a", 0, 32'h0);
      expect_val("r0_next_b", 1, 32'h0);
      drain();

      wr(5'd25, 32'h000000FF);
      ctrl_readRegA = 5'd25;
      ctrl_readRegB = 5'd7;
      expect_val("out_pre", 2, 32'h0);
      drain();
      tick();
      ctrl_writeEnable = 1'b0;
      expect_val("out_post", 2, 32'hFF);
      expect_val("r25_rd", 0, 32'hFF);
      expect_val("r7_rd", 1, 32'h55AA);
      drain();
      wr(5'd5, 32'h0BADF00D);
      ctrl_reset = 1'b1;
      tick();
      ctrl_reset = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_readRegB = 5'd5;
      expect_val("out_rst", 2, 32'h0);
      expect_val("r25_rst", 0, 32'h0);
      expect_val("r5_rst_wins", 1, 32'h0);
      drain();

      ctrl_readRegA = 5'd26;
      tick();
      tick();
      tick();
      expect_val("r26_flag", 0, 32'h1A5);
      drain();
      io_in = 24'hFF005A;
      tick();
      tick();
      wr(5'd26, 32'hFFFFFFFF);
      expect_val("in_no_byp", 0, 32'h1A5);
      drain();
      tick();
      ctrl_writeEnable = 1'b0;
      expect_val("set_wins", 0, 32'h15A);
      expect_val("set_wins_chg", 3, 32'h5);
      drain();
      wr(5'd26, 32'h0);
      tick();
      ctrl_writeEnable = 1'b0;
      expect_val("clr_r26", 0, 32'h05A);
      expect_val("clr_chg", 3, 32'h4);
      drain();

      io_in = 24'h0;
      ctrl_reset = 1'b1;
      tick();
      ctrl_reset = 1'b0;
      io_in = 24'h00003C;
      tick();
      expect_val("lat_e1", 0, 32'h0);
      drain();
      tick();
      expect_val("lat_e2", 0, 32'h0);
      drain();
      tick();
      expect_val("lat_e3", 0, 32'h13C);
      expect_val("lat_chg", 3, 32'h1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
